// File: rtl/controle_multiciclo_if.sv
// Control bus between the multicycle MIPS datapath and its main control FSM.
// The datapath side drives the opcode and the memory-ready handshake; the controller drives the rest.
interface controle_multiciclo_if;
    logic [5:0] Opcode;
    logic       Mem_Pronta;
    logic       PC_Write;
    logic       PC_Write_Cond;
    logic       IorD;
    logic       Mem_Read;
    logic       Mem_Write;
    logic       Mem_to_Reg;
    logic       IR_Write;
    logic       ALU_Src_A;
    logic       Reg_Write;
    logic       Reg_Dst;
    logic [1:0] PC_Source;
    logic [1:0] ALU_Src_B;
    logic [1:0] Op_ALU;
    logic       Opcode_Invalido;
    logic [3:0] Estado;

    modport master (
        output Opcode, Mem_Pronta,
        input  PC_Write, PC_Write_Cond, IorD, Mem_Read, Mem_Write, Mem_to_Reg,
               IR_Write, ALU_Src_A, Reg_Write, Reg_Dst, PC_Source, ALU_Src_B,
               Op_ALU, Opcode_Invalido, Estado
    );

    modport slave (
        input  Opcode, Mem_Pronta,
        output PC_Write, PC_Write_Cond, IorD, Mem_Read, Mem_Write, Mem_to_Reg,
               IR_Write, ALU_Src_A, Reg_Write, Reg_Dst, PC_Source, ALU_Src_B,
               Op_ALU, Opcode_Invalido, Estado
    );
endinterface

// File: rtl/controle_multiciclo.sv
// Main control FSM of the multicycle MIPS datapath (Moore, with IR_Write/PC_Write following Mem_Pronta in BUSCA).
// Optional feature: define CONTROLE_ADDI_EN to decode addi through EXECUTA_I/ESCREVE_I.
module controle_multiciclo (
    input  logic                  clock,
    input  logic                  reset_n,
    controle_multiciclo_if.slave  bus
);

    typedef enum logic [3:0] {
        OCIOSO          = 4'd0,
        BUSCA           = 4'd1,
        DECODIFICA      = 4'd2,
        CALC_END        = 4'd3,
        LEITURA_MEM     = 4'd4,
        ESCREVE_MEM_REG = 4'd5,
        ESCRITA_MEM     = 4'd6,
        EXECUTA_R       = 4'd7,
        ESCREVE_R       = 4'd8,
        DESVIO          = 4'd9,
        SALTO           = 4'd10,
        EXECUTA_I       = 4'd11,
        ESCREVE_I       = 4'd12
    } estado_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_src_b;
        logic [1:0] op_alu;
    } controle_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
`ifdef CONTROLE_ADDI_EN
    localparam logic [5:0] OP_ADDI = 6'b001000;
`endif

    estado_t   estado;
    estado_t   estado_prox;
    logic      invalido_q;
    logic      invalido_prox;
    controle_t ctrl;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado     <= OCIOSO;
            invalido_q <= 1'b0;
        end else begin
            estado     <= estado_prox;
            invalido_q <= invalido_prox;
        end
    end

    // NOTE: defaults are assigned first so no path through the case leaves a signal unassigned (no latches).
    always_comb begin
        estado_prox   = BUSCA;
        invalido_prox = 1'b0;
        unique case (estado)
            OCIOSO:      estado_prox = BUSCA;
            BUSCA:       estado_prox = bus.Mem_Pronta ? DECODIFICA : BUSCA;
            DECODIFICA: begin
                case (bus.Opcode)
                    OP_R:         estado_prox = EXECUTA_R;
                    OP_LW, OP_SW: estado_prox = CALC_END;
                    OP_BEQ:       estado_prox = DESVIO;
                    OP_J:         estado_prox = SALTO;
`ifdef CONTROLE_ADDI_EN
                    OP_ADDI:      estado_prox = EXECUTA_I;
`endif
                    default:      invalido_prox = 1'b1;
                endcase
            end
            CALC_END:    estado_prox = (bus.Opcode == OP_SW) ? ESCRITA_MEM : LEITURA_MEM;
            LEITURA_MEM: estado_prox = bus.Mem_Pronta ? ESCREVE_MEM_REG : LEITURA_MEM;
            ESCRITA_MEM: estado_prox = bus.Mem_Pronta ? BUSCA : ESCRITA_MEM;
            EXECUTA_R:   estado_prox = ESCREVE_R;
`ifdef CONTROLE_ADDI_EN
            EXECUTA_I:   estado_prox = ESCREVE_I;
`endif
            // Write-back states, branch, jump and every unused encoding return to fetch.
            default:     estado_prox = BUSCA;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (estado)
            BUSCA: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = 2'b01;
                // The fetch completes, and PC+4 is committed, only in the cycle memory is ready.
                ctrl.ir_write  = bus.Mem_Pronta;
                ctrl.pc_write  = bus.Mem_Pronta;
            end
            DECODIFICA: ctrl.alu_src_b = 2'b11;
            CALC_END: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
            end
            LEITURA_MEM: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            ESCRITA_MEM: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            ESCREVE_MEM_REG: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            EXECUTA_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.op_alu    = 2'b10;
            end
            ESCREVE_R: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            DESVIO: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.op_alu        = 2'b01;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = 2'b01;
            end
            SALTO: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = 2'b10;
            end
`ifdef CONTROLE_ADDI_EN
            EXECUTA_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = 2'b10;
            end
            ESCREVE_I: ctrl.reg_write = 1'b1;
`endif
            default: ctrl = '0;
        endcase
    end

    assign bus.PC_Write        = ctrl.pc_write;
    assign bus.PC_Write_Cond   = ctrl.pc_write_cond;
    assign bus.IorD            = ctrl.iord;
    assign bus.Mem_Read        = ctrl.mem_read;
    assign bus.Mem_Write       = ctrl.mem_write;
    assign bus.Mem_to_Reg      = ctrl.mem_to_reg;
    assign bus.IR_Write        = ctrl.ir_write;
    assign bus.ALU_Src_A       = ctrl.alu_src_a;
    assign bus.Reg_Write       = ctrl.reg_write;
    assign bus.Reg_Dst         = ctrl.reg_dst;
    assign bus.PC_Source       = ctrl.pc_source;
    assign bus.ALU_Src_B       = ctrl.alu_src_b;
    assign bus.Op_ALU          = ctrl.op_alu;
    assign bus.Opcode_Invalido = invalido_q;
    assign bus.Estado          = estado;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Self-checking bench for controle_multiciclo: an instruction-level model expands each opcode
// into the expected per-cycle state/output trace, with randomized memory stalls.
module tb_controle_multiciclo;

    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_fail;
    logic pending_inv;

    controle_multiciclo_if bus ();

    controle_multiciclo dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef enum int {I_R, I_LW, I_SW, I_BEQ, I_J, I_ADDI, I_BAD} classe_t;

    // {PC_Write, PC_Write_Cond, IorD, Mem_Read, Mem_Write, Mem_to_Reg, IR_Write,
    //  ALU_Src_A, Reg_Write, Reg_Dst, PC_Source, ALU_Src_B, Op_ALU}
    function automatic logic [15:0] observado();
        return {bus.PC_Write, bus.PC_Write_Cond, bus.IorD, bus.Mem_Read, bus.Mem_Write,
                bus.Mem_to_Reg, bus.IR_Write, bus.ALU_Src_A, bus.Reg_Write, bus.Reg_Dst,
                bus.PC_Source, bus.ALU_Src_B, bus.Op_ALU};
    endfunction

    function automatic logic [15:0] esperado(int st, logic mp);
        logic pcw, pcwc, iord, mr, mw, m2r, irw, asa, rw, rd;
        logic [1:0] pcs, asb, op;
        {pcw, pcwc, iord, mr, mw, m2r, irw, asa, rw, rd} = '0;
        pcs = 2'b00; asb = 2'b00; op = 2'b00;
        case (st)
            1:  begin mr = 1; asb = 2'b01; irw = mp; pcw = mp; end
            2:  asb = 2'b11;
            3:  begin asa = 1; asb = 2'b10; end
            4:  begin mr = 1; iord = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin mw = 1; iord = 1; end
            7:  begin asa = 1; op = 2'b10; end
            8:  begin rw = 1; rd = 1; end
            9:  begin asa = 1; op = 2'b01; pcwc = 1; pcs = 2'b01; end
            10: begin pcw = 1; pcs = 2'b10; end
            11: begin asa = 1; asb = 2'b10; end
            12: rw = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mr, mw, m2r, irw, asa, rw, rd, pcs, asb, op};
    endfunction

    function automatic classe_t classifica(logic [5:0] op);
        case (op)
            6'b000000: return I_R;
            6'b100011: return I_LW;
            6'b101011: return I_SW;
            6'b000100: return I_BEQ;
            6'b000010: return I_J;
`ifdef CONTROLE_ADDI_EN
            6'b001000: return I_ADDI;
`endif
            default:   return I_BAD;
        endcase
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_checks++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive Mem_Pronta, let outputs settle, compare, then advance past the edge.
    task automatic step(input int st, input logic mp);
        bus.Mem_Pronta = mp;
        #1;
        check($sformatf("estado(exp %0d)", st), {12'b0, bus.Estado}, st[15:0]);
        check($sformatf("saidas(estado %0d)", st), observado(), esperado(st, mp));
        check($sformatf("invalido(estado %0d)", st), {15'b0, bus.Opcode_Invalido}, {15'b0, pending_inv});
        pending_inv = 1'b0;
        @(posedge clock);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input int rb, input int rm);
        classe_t c;
        c = classifica(op);
        bus.Opcode = op;
        for (int k = 0; k < rb; k++) step(1, 1'b0);
        step(1, 1'b1);
        step(2, 1'($urandom));
        case (c)
            I_R:    begin step(7, 1'($urandom)); step(8, 1'($urandom)); end
            I_LW: begin
                step(3, 1'($urandom));
                for (int k = 0; k < rm; k++) step(4, 1'b0);
                step(4, 1'b1);
                step(5, 1'($urandom));
            end
            I_SW: begin
                step(3, 1'($urandom));
                for (int k = 0; k < rm; k++) step(6, 1'b0);
                step(6, 1'b1);
            end
            I_BEQ:  step(9, 1'($urandom));
            I_J:    step(10, 1'($urandom));
            I_ADDI: begin step(11, 1'($urandom)); step(12, 1'($urandom)); end
            default: pending_inv = 1'b1;
        endcase
    endtask

    initial begin
        logic [5:0] ops [7];
        logic [5:0] op;
        n_checks    = 0;
        n_fail      = 0;
        pending_inv = 1'b0;
        reset_n     = 1'b0;
        bus.Opcode  = 6'b100011;
        bus.Mem_Pronta = 1'b1;
        ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011; ops[3] = 6'b000100;
        ops[4] = 6'b000010; ops[5] = 6'b001000; ops[6] = 6'b111111;

        // Reset held across several edges.
        #23;
        check("reset_estado", {12'b0, bus.Estado}, 16'd0);
        check("reset_saidas", observado(), 16'h0000);
        check("reset_invalido", {15'b0, bus.Opcode_Invalido}, 16'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("pos_reset_ocioso", {12'b0, bus.Estado}, 16'd0);
        @(posedge clock);
        #1;

        // Directed instructions.
        run_instr(6'b100011, 0, 0);   // lw, 5 cycles
        run_instr(6'b101011, 0, 3);   // sw with a 3-cycle memory stall
        run_instr(6'b000000, 1, 0);   // R-type with one fetch stall
        run_instr(6'b000100, 0, 0);   // beq
        run_instr(6'b000010, 0, 0);   // j
        run_instr(6'b111111, 0, 0);   // invalid
        run_instr(6'b001000, 2, 0);   // addi (invalid unless enabled); pulse from previous in stalled fetch
        run_instr(6'b100011, 0, 2);   // lw with read stall

        // Randomized instruction stream.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) op = 6'($urandom);
            else                           op = ops[$urandom_range(0, 6)];
            run_instr(op, $urandom_range(0, 2), $urandom_range(0, 2));
        end
        run_instr(6'b101011, 0, 0);

        // Reset in the middle of a stalled store.
        bus.Opcode = 6'b101011;
        step(1, 1'b1);
        step(2, 1'b1);
        step(3, 1'b1);
        step(6, 1'b0);
        bus.Mem_Pronta = 1'b0;
        #1;
        check("escrita_antes_reset", {15'b0, bus.Mem_Write}, 16'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("reset_meio_mem_write", {15'b0, bus.Mem_Write}, 16'd0);
        check("reset_meio_estado", {12'b0, bus.Estado}, 16'd0);
        check("reset_meio_saidas", observado(), 16'h0000);
        #3;
        reset_n = 1'b1;
        #1;
        check("reset_meio_ocioso", {12'b0, bus.Estado}, 16'd0);
        @(posedge clock);
        #1;
        run_instr(6'b000000, 0, 0);
        step(1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/controle_multiciclo.md
# controle_multiciclo

- Main control FSM of the multicycle MIPS datapath; sits directly upstream of the ALU control stage.
- Decodes the 6-bit instruction opcode over several clock cycles and drives every datapath enable and mux select.
- Produces the 2-bit `Op_ALU` that the ALU control stage combines with the funct field.
- Waits on a memory-ready handshake for each memory access.

## Interface
Parameters: none.
- `clock`  in  1  system clock, rising-edge active
- `reset_n`  in  1  reset, asynchronous, active-low; one clock domain
- `Opcode`  in  6  instruction[31:26] from the instruction register
- `Mem_Pronta`  in  1  memory ready; the access completes in a cycle where it is 1
- `PC_Write`, `PC_Write_Cond`, `IorD`, `Mem_Read`, `Mem_Write`, `Mem_to_Reg`, `IR_Write`, `ALU_Src_A`, `Reg_Write`, `Reg_Dst`  out  1 each  datapath controls
- `PC_Source`  out  2  PC mux select: 00 ALU, 01 ALUOut, 10 jump target
- `ALU_Src_B`  out  2  ALU B select: 00 reg B, 01 constant 4, 10 sign-extended immediate, 11 shifted sign-extended immediate
- `Op_ALU`  out  2  to ALU control: 00 add, 01 subtract, 10 use funct
- `Opcode_Invalido`  out  1  registered one-cycle pulse on an undecodable opcode
- `Estado`  out  4  current state encoding, for debug

## Operation
State encodings:
- 0 OCIOSO, 1 BUSCA, 2 DECODIFICA, 3 CALC_END, 4 LEITURA_MEM, 5 ESCREVE_MEM_REG
- 6 ESCRITA_MEM, 7 EXECUTA_R, 8 ESCREVE_R, 9 DESVIO, 10 SALTO, 11 EXECUTA_I, 12 ESCREVE_I
- 13–15 are unused and return to BUSCA on the next edge.

Output rules:
- Outputs are decoded from the state (Moore), except `IR_Write` and `PC_Write` in BUSCA, which equal `Mem_Pronta`.
- Any output not listed for a state is 0.

Per-state outputs:
- OCIOSO: all outputs 0.
- BUSCA: `Mem_Read`=1, `IorD`=0, `ALU_Src_A`=0, `ALU_Src_B`=01, `Op_ALU`=00, `PC_Source`=00.
- DECODIFICA: `ALU_Src_A`=0, `ALU_Src_B`=11, `Op_ALU`=00.
- CALC_END and EXECUTA_I: `ALU_Src_A`=1, `ALU_Src_B`=10, `Op_ALU`=00.
- LEITURA_MEM: `Mem_Read`=1, `IorD`=1.
- ESCRITA_MEM: `Mem_Write`=1, `IorD`=1.
- ESCREVE_MEM_REG: `Reg_Write`=1, `Mem_to_Reg`=1, `Reg_Dst`=0.
- EXECUTA_R: `ALU_Src_A`=1, `ALU_Src_B`=00, `Op_ALU`=10.
- ESCREVE_R: `Reg_Write`=1, `Reg_Dst`=1.
- DESVIO: `ALU_Src_A`=1, `ALU_Src_B`=00, `Op_ALU`=01, `PC_Write_Cond`=1, `PC_Source`=01.
- SALTO: `PC_Write`=1, `PC_Source`=10.
- ESCREVE_I: `Reg_Write`=1, `Reg_Dst`=0, `Mem_to_Reg`=0.

Transitions:
- OCIOSO→BUSCA unconditionally.
- BUSCA stays in BUSCA while `Mem_Pronta`=0, then goes to DECODIFICA.
- DECODIFICA, by opcode:
  - 000000 (R-type) → EXECUTA_R
  - 100011 (lw) or 101011 (sw) → CALC_END
  - 000100 (beq) → DESVIO
  - 000010 (j) → SALTO
  - 001000 (addi) → EXECUTA_I, only with the macro enabled
  - anything else → BUSCA, and `Opcode_Invalido` pulses 1 in the next cycle.
- CALC_END: lw → LEITURA_MEM; sw → ESCRITA_MEM.
- LEITURA_MEM and ESCRITA_MEM hold, with outputs held, while `Mem_Pronta`=0. On `Mem_Pronta`=1: LEITURA_MEM→ESCREVE_MEM_REG and ESCRITA_MEM→BUSCA.
- ESCREVE_MEM_REG, ESCREVE_R, ESCREVE_I, DESVIO and SALTO → BUSCA.
- EXECUTA_R→ESCREVE_R; EXECUTA_I→ESCREVE_I.

Opcode sampling: `Opcode` is read only in DECODIFICA and CALC_END. The instruction register is stable at those times.

## Timing
- Reset: `reset_n`=0 forces state OCIOSO immediately, independent of `clock`.
  - All outputs read 0, including `Opcode_Invalido` and `Estado`.
  - Reset is legal mid-instruction; the instruction is abandoned and no write strobe stays asserted.
- First BUSCA: the first rising edge after `reset_n` rises moves OCIOSO→BUSCA.
- Cycles per instruction with `Mem_Pronta` held at 1, BUSCA included:
  - j and beq: 3
  - R-type, sw and addi: 4
  - lw: 5
- Each cycle with `Mem_Pronta`=0 in BUSCA, LEITURA_MEM or ESCRITA_MEM adds exactly one cycle.
- `Opcode_Invalido` is high for exactly one cycle, the first BUSCA cycle after the bad DECODIFICA.

## Configuration
Macro: `CONTROLE_ADDI_EN`.
- Defined: opcode 001000 takes the path DECODIFICA→EXECUTA_I→ESCREVE_I→BUSCA.
- Undefined:
  - 001000 is treated as invalid: the FSM returns to BUSCA and `Opcode_Invalido` pulses.
  - Encodings 11 and 12 are unused and return to BUSCA on the next edge.

## Test plan
- **Reset:** hold `reset_n`=0 → all outputs 0 and `Estado`=0. Release → `Estado` sequence 1,2 on the next two edges.
- **lw:** `Opcode`=100011, `Mem_Pronta`=1 → `Estado` 1,2,3,4,5,1. `Reg_Write`=1 and `Mem_to_Reg`=1 in state 5 only.
- **Memory stall:** sw with `Mem_Pronta`=0 for 3 cycles in ESCRITA_MEM → `Mem_Write` stays 1 for 4 cycles, then state 1. Total is 7 cycles.
- **R-type:** `Opcode`=000000 → `Op_ALU`=10 in state 7, then `Reg_Dst`=1 and `Reg_Write`=1 in state 8. beq → `Op_ALU`=01 and `PC_Write_Cond`=1 in state 9.
- **Invalid opcode and addi:** `Opcode`=111111 → back to state 1 with `Opcode_Invalido` high for exactly one cycle. addi with the macro defined → states 11,12. addi without the macro → the invalid-opcode pulse.
- **Reset mid-instruction:** assert `reset_n`=0 mid-cycle in state 6 → `Mem_Write` drops to 0 before the next edge, and `Estado`=0.
